// File: rtl/im_loader_pkg.sv
// im_loader_pkg: state encoding and framing constants shared by the program loader files.
package im_loader_pkg;
  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/im_word_packer.sv
// im_word_packer: gathers big-endian bytes into 32-bit words with a one-cycle word_valid per word.
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        last,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [23:0] sh;
  logic [1:0]  idx;
  assign last = idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sh <= '0;
      idx <= '0;
      word_valid <= 1'b0;
      word <= '0;
    end else if (clear) begin
      sh <= '0;
      idx <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take && last;
      if (take) begin
        idx <= idx + 2'd1;
        sh <= {sh[15:0], data};
        if (last) word <= {sh, data};
      end
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: streams a counted big-endian image into instruction memory, then releases the CPU.
// Optional trailing XOR checksum byte when IM_LOADER_CHECKSUM_EN is defined.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);
  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(1) << ADDR_W;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, wcnt, hdr;
  logic take, data_take, last, restart;
  assign hdr = {cnt[CNT_W-1:8], byte_data};
  assign take = byte_valid && byte_ready;
  assign data_take = take && state == S_DATA;
  assign restart = reload && (state == S_DONE || state == S_ERR);
`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
  logic [7:0] csum;
  assign byte_ready = !reset && (state inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM});
  always_ff @(posedge clock or posedge reset)
    if (reset) csum <= '0;
    else if (restart) csum <= '0;
    else if (data_take) csum <= csum ^ byte_data;
`else
  localparam state_t S_TAIL = S_DONE;
  assign byte_ready = !reset && (state inside {S_CNT_HI, S_CNT_LO, S_DATA});
`endif
  im_word_packer u_pack (
    .clock(clock),
    .reset(reset),
    .clear(restart),
    .take(data_take),
    .data(byte_data),
    .last(last),
    .word_valid(im_we),
    .word(im_wdata)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_CNT_HI: nxt = take ? S_CNT_LO : S_CNT_HI;
      S_CNT_LO: if (take) nxt = hdr == '0 ? S_TAIL : ({1'b0, hdr} > MAX_WORDS ? S_ERR : S_DATA);
      S_DATA:   if (data_take && last && wcnt == cnt - 1'b1) nxt = S_TAIL;
`ifdef IM_LOADER_CHECKSUM_EN
      S_CSUM:   if (take) nxt = byte_data == csum ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (reload) nxt = S_CNT_HI;
      default:  nxt = S_CNT_HI;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_CNT_HI;
      cnt <= '0;
      wcnt <= '0;
      im_addr <= '0;
    end else begin
      state <= nxt;
      if (restart) wcnt <= '0;
      if (take && state == S_CNT_HI) cnt <= CNT_W'({byte_data, 8'h00});
      if (take && state == S_CNT_LO) cnt <= hdr;
      if (data_take && last) begin
        im_addr <= wcnt[ADDR_W-1:0];
        wcnt <= wcnt + 1'b1;
      end
    end
  // done waits out the final write pulse so the CPU never runs alongside it
  assign done = state == S_DONE && !im_we;
  assign cpu_run = done;
  assign err = state == S_ERR;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized image loads checked against a queue-based model of the loader.
module tb_im_loader;
  localparam int ADDR_W = 10;
  localparam int CAP = 1 << ADDR_W;
  logic clock = 1'b0;
  logic reset, byte_valid, reload, byte_ready, im_we, cpu_run, done, err;
  logic [7:0] byte_data;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_wdata;
  int checks = 0, errors = 0, cyc = 0, data_stall = 0, done_cyc = 0;
  bit done_seen = 0;
  logic [31:0] words[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0] got_data[$];
  int got_cyc[$];

  im_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_run(cpu_run), .done(done), .err(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      got_addr.push_back(im_addr);
      got_data.push_back(im_wdata);
      got_cyc.push_back(cyc);
    end
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_we"}, im_we, 0);
    chk({tag, "_addr"}, im_addr, 0);
    chk({tag, "_wdata"}, im_wdata, 0);
    chk({tag, "_run"}, cpu_run, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, output int stall);
    int n = 0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clock);
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    stall = n;
    if (!byte_ready) chk("ready_timeout", 0, 1);
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1 reload = 1'b0;
    @(negedge clock);
    chk("reload_run", cpu_run, 0);
    chk("reload_done", done, 0);
    chk("reload_err", err, 0);
  endtask

  task automatic fill(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  // Model: an in-range image writes word i to address i; success also needs a matching checksum
  task automatic run_image(input int cnt, input int gap_max, input int bad);
    logic [15:0] c;
    logic [31:0] w;
    logic [7:0] x;
    int st, exp_n;
    bit ok;
    c = 16'(cnt);
    x = '0;
    data_stall = 0;
    done_seen = 0;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    ok = cnt <= CAP && bad == 0;
    exp_n = cnt <= CAP ? cnt : 0;
    send_byte(c[15:8], gap_max, st);
    send_byte(c[7:0], gap_max, st);
    for (int i = 0; i < exp_n; i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[8*k +: 8], gap_max, st);
        x ^= w[8*k +: 8];
        data_stall += st;
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    if (cnt <= CAP) send_byte(x ^ 8'(bad), gap_max, st);
`endif
    for (int n = 0; n < 40 && done !== 1'b1 && err !== 1'b1; n++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk("done", done, ok);
    chk("run", cpu_run, ok);
    chk("err", err, !ok);
    chk("ready_idle", byte_ready, 0);
    chk("n_writes", got_addr.size(), exp_n);
    if (got_addr.size() == exp_n)
      for (int i = 0; i < exp_n; i++) begin
        chk("waddr", got_addr[i], i);
        chk("wdata", got_data[i], words[i]);
      end
`ifndef IM_LOADER_CHECKSUM_EN
    if (ok && cnt > 0 && got_cyc.size() > 0) chk("done_latency", done_cyc - got_cyc[$], 1);
`endif
  endtask

  initial begin
    int st, n, bad;
    reset = 1'b1;
    byte_valid = 1'b0;
    byte_data = '0;
    reload = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset("rst");
    reset = 1'b0;

    words = '{32'h20080005};
    run_image(1, 0, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    do_reload();
    run_image(1, 0, 1);
`endif

    do_reload();
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_image(3, 0, 0);
    chk("burst_stall", data_stall, 0);
    if (got_cyc.size() == 3) begin
      chk("burst_gap0", got_cyc[1] - got_cyc[0], 4);
      chk("burst_gap1", got_cyc[2] - got_cyc[1], 4);
    end

    do_reload();
    run_image(0, 1, 0);
    do_reload();
    run_image(CAP + 1, 1, 0);

    do_reload();
    words = '{32'h01020304, 32'h05060708};
    send_byte(8'h00, 0, st);
    send_byte(8'h02, 0, st);
    for (int k = 3; k >= 0; k--) send_byte(words[0][8*k +: 8], 0, st);
    send_byte(8'h05, 0, st);
    send_byte(8'h06, 0, st);
    @(negedge clock);
    reset = 1'b1;
    #1 chk_reset("midrst");
    @(negedge clock);
    reset = 1'b0;
    words = '{32'hDEADBEEF};
    run_image(1, 1, 0);

    for (int t = 0; t < 8; t++) begin
      do_reload();
      n = $urandom_range(9, 0);
      n = n == 0 ? 0 : (n == 1 ? CAP + $urandom_range(40, 1) : $urandom_range(6, 1));
      fill(n <= CAP ? n : 0);
      bad = 0;
`ifdef IM_LOADER_CHECKSUM_EN
      if ($urandom_range(3, 0) == 0) bad = $urandom_range(255, 1);
`endif
      run_image(n, 2, bad);
    end

    do_reload();
    fill(CAP);
    run_image(CAP, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Hardware program loader for the single-cycle MIPS CPU; it does in silicon what the simulation bench does with its instruction-memory preload and reset sequencing.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a one-word write port.
- Holds the CPU out of run until the whole image is in memory, then releases it.

Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity is 2^ADDR_W words.
- CNT_W, 16, width of the word-count header; fixed at 2 bytes.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; returns the block to S_CNT_HI.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  in S_DONE or S_ERR, restarts loading.
- im_we  output  1  instruction memory write strobe, one-cycle pulse.
- im_addr  output  ADDR_W  word address for the write.
- im_wdata  output  32  word to write.
- cpu_run  output  1  high means the CPU may execute; the CPU is held in reset while low.
- done  output  1  image loaded successfully.
- err  output  1  load failed.

Behaviour:
- Reset values: byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_run=0, done=0, err=0.
- Internal state on reset: state=S_CNT_HI, word counter=0, byte index=0.
- Handshake: a byte transfers on the rising edge where byte_valid&&byte_ready.
  - byte_ready=1 in S_CNT_HI, S_CNT_LO and S_DATA (and S_CSUM when enabled); 0 in all other states.
  - byte_ready is combinational from state only; it never depends on byte_valid.
- S_CNT_HI: accept count[15:8], then go to S_CNT_LO.
- S_CNT_LO: accept count[7:0], then choose the next state:
  - count==0: go to S_DONE.
  - count>2^ADDR_W: go to S_ERR.
  - otherwise: go to S_DATA.
- S_DATA, word assembly:
  - Bytes arrive MSB first: byte0 goes to [31:24] and byte3 to [7:0].
  - On the edge that accepts byte3, register im_wdata=assembled word and im_addr=word index, and set im_we=1 for exactly the next cycle.
  - The word index starts at 0 and increments by 1 per word; it never wraps because count is bounded.
  - Back-to-back bytes at full rate are supported with no stall.
- After the write of word count-1 is issued, the next state is S_DONE; done and cpu_run go high on the cycle after the last im_we pulse.
- S_DONE: done=1, cpu_run=1, err=0. reload=1 goes to S_CNT_HI and clears done and cpu_run on the next edge.
- S_ERR: err=1, cpu_run=0, done=0. The block stays here until reset or reload.
- Ignored inputs: byte_valid in S_DONE or S_ERR is ignored; reload outside S_DONE or S_ERR is ignored.
- Reset mid-word or mid-image: all partial state is discarded and loading restarts from the header. Words already written to memory are not cleared.
- Simultaneous events: reset dominates reload and any handshake.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data byte the FSM enters S_CSUM and accepts one byte.
  - That byte must equal the XOR of all data bytes (header excluded).
  - On match, go to S_DONE; on mismatch, go to S_ERR.
  - With count==0 the expected checksum is 0x00.
  - The final im_we still occurs before the checksum byte is taken; cpu_run stays 0 until the checksum passes.
- When undefined: there is no S_CSUM state and no checksum register; behaviour is exactly as above.

Decomposition:
- Package im_loader_pkg holds:
  - state encoding localparams S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR (3 bits);
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2.
- One sub-module, im_word_packer:
  - shift register plus 2-bit byte index;
  - outputs word_valid (one-cycle) and word;
  - cleared by reset or by the FSM's restart.
- The FSM, counters and checksum live in im_loader.

Test Plan:
- Single word: send 00 01 20 08 00 05 → im_we pulses once, im_addr=0, im_wdata=0x20080005; done=1 and cpu_run=1 the next cycle.
- Full-rate burst: count=3, words 0x11111111, 0x22222222, 0x33333333 with byte_valid held high → three im_we pulses at addresses 0, 1, 2, four cycles apart; byte_ready never drops in S_DATA.
- Zero and oversize count:
  - count 0x0000 → done=1 with no im_we.
  - count 0x0401 with ADDR_W=10 → err=1, cpu_run=0, byte_ready=0.
- Reset mid-word: assert reset after 2 data bytes of word 1 → all outputs return to reset values; reloading 00 01 DE AD BE EF writes 0xDEADBEEF at address 0.
- Reload: from S_DONE pulse reload → cpu_run falls the next cycle; a new image loads and done reasserts.
- IM_LOADER_CHECKSUM_EN:
  - word 0x20080005 with checksum byte 0x2D → done=1.
  - checksum byte 0x2C → err=1, cpu_run=0.
